btn_pulse_gen: RTL and testbench

- Front-end conditioner for lab push-buttons; sits directly upstream of the board counters.
- Converts a raw, bouncing, asynchronous button into a debounced level plus single-cycle pulses.
- `pulse` drives a counter's count-enable or load-enable input.
- Optional hold-to-repeat mode emits periodic pulses while the button stays held.

---
 rtl/btn_pulse_gen.sv | 143 ++++++++++++++
 tb/tb_btn_pulse_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_gen.sv
// rtl/btn_pulse_gen.sv - push-button conditioner: debounced level, press/release strobes, hold-to-repeat
module btn_pulse_gen #(
  parameter int TICK_DIV   = 100000,
  parameter int DB_TICKS   = 10,
  parameter int HOLD_TICKS = 500,
  parameter int RPT_TICKS  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic rpt_en,
  output logic level,
  output logic pulse,
  output logic rel_pulse
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(RPT_TICKS + 1);

  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_REL} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [PW-1:0]   pre_q;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic            rel_q, rel_d;
  logic            s;
  logic            tick;

  assign s    = sync2_q;
  assign tick = (pre_q == PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      pre_q      <= '0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rpt_cnt_q  <= '0;
      level_q    <= 1'b0;
      pulse_q    <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      pre_q      <= tick ? '0 : pre_q + 1'b1;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rpt_cnt_q  <= rpt_cnt_d;
      level_q    <= level_d;
      pulse_q    <= pulse_d;
      rel_q      <= rel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rpt_cnt_d  = rpt_cnt_q;
    level_d    = level_q;
    pulse_d    = 1'b0;
    rel_d      = 1'b0;
    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (s) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
        end else if (tick) begin
          if (db_cnt_q == DB_MAX) begin
            state_d    = PRESSED;
            level_d    = 1'b1;
            pulse_d    = 1'b1;
            hold_cnt_d = '0;
            rpt_cnt_d  = '0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d  = DB_REL;
          db_cnt_d = '0;
        end else if (!rpt_en) begin
          hold_cnt_d = '0;
          rpt_cnt_d  = '0;
        end else if (tick) begin
          // hold_cnt saturates at HOLD_MAX; only then does the repeat period run
          if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            pulse_d    = (hold_cnt_q == HOLD_LAST);
          end else if (rpt_cnt_q == RPT_LAST) begin
            rpt_cnt_d = '0;
            pulse_d   = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
      end
      DB_REL: begin
        if (s) begin
          state_d = PRESSED;
        end else if (tick) begin
          if (db_cnt_q == DB_MAX) begin
            state_d = IDLE;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level     = level_q;
  assign pulse     = pulse_q;
  assign rel_pulse = rel_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb/tb_btn_pulse_gen.sv - self-checking bench for btn_pulse_gen against a behavioural model
module tb_btn_pulse_gen;

  localparam int TICK_DIV   = 4;
  localparam int DB_TICKS   = 3;
  localparam int HOLD_TICKS = 5;
  localparam int RPT_TICKS  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic rpt_en = 1'b0;
  logic level, pulse, rel_pulse;

  always #5 clk = ~clk;

  btn_pulse_gen #(
    .TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS),
    .HOLD_TICKS(HOLD_TICKS), .RPT_TICKS(RPT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .rpt_en(rpt_en),
    .level(level), .pulse(pulse), .rel_pulse(rel_pulse)
  );

  // Behavioural model: button seen two edges late, tick every TICK_DIV-th edge since reset
  bit m_valid = 1'b0;
  bit m_lvl, m_pulse, m_rel, m_pend;
  int m_dbc, m_hold, m_rpt, k;
  int cyc = 0;
  bit sq[$];

  always @(posedge clk) begin
    bit s_m, t_m;
    cyc++;
    if (rst) begin
      m_valid = 1'b1;
      k = 0;
      sq = '{1'b0, 1'b0};
      m_lvl = 0; m_pulse = 0; m_rel = 0; m_pend = 0;
      m_dbc = 0; m_hold = 0; m_rpt = 0;
    end else begin
      s_m = sq.pop_front();
      sq.push_back(btn_in);
      t_m = ((k % TICK_DIV) == TICK_DIV - 1);
      k++;
      m_pulse = 0;
      m_rel = 0;
      if (!m_lvl) begin
        if (!m_pend) begin
          if (s_m) begin m_pend = 1; m_dbc = 0; end
        end else if (!s_m) begin
          m_pend = 0;
        end else if (t_m) begin
          if (m_dbc == DB_TICKS - 1) begin
            m_lvl = 1; m_pend = 0; m_pulse = 1; m_hold = 0; m_rpt = 0;
          end else m_dbc++;
        end
      end else begin
        if (!m_pend) begin
          if (!s_m) begin
            m_pend = 1; m_dbc = 0;
          end else if (!rpt_en) begin
            m_hold = 0; m_rpt = 0;
          end else if (t_m) begin
            if (m_hold < HOLD_TICKS) begin
              m_hold++;
              m_pulse = (m_hold == HOLD_TICKS);
            end else begin
              m_rpt++;
              if (m_rpt == RPT_TICKS) begin m_pulse = 1; m_rpt = 0; end
            end
          end
        end else if (s_m) begin
          m_pend = 0;
        end else if (t_m) begin
          if (m_dbc == DB_TICKS - 1) begin
            m_lvl = 0; m_pend = 0; m_rel = 1;
          end else m_dbc++;
        end
      end
    end
  end

  logic [2:0] cnt3;
  always @(posedge clk) begin
    if (rst) cnt3 <= 3'd0;
    else if (pulse) cnt3 <= cnt3 + 3'd1;
  end

  int n_chk = 0, n_pass = 0;
  int n_pulse = 0, n_rel = 0, n_rise = 0, n_fall = 0;
  logic prev_level = 1'b0;
  int ptimes[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    if (m_valid) begin
      chk("level", level, m_lvl);
      chk("pulse", pulse, m_pulse);
      chk("rel_pulse", rel_pulse, m_rel);
    end
    if (pulse === 1'b1) begin n_pulse++; ptimes.push_back(cyc); end
    if (rel_pulse === 1'b1) n_rel++;
    if (prev_level !== 1'b1 && level === 1'b1) n_rise++;
    if (prev_level === 1'b1 && level === 1'b0) n_fall++;
    prev_level = level;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic wait_level_high();
    for (int i = 0; i < 60; i++) begin
      step();
      if (level === 1'b1) break;
    end
    chk("level_seen", level, 1'b1);
  endtask

  task automatic repeat_run(input logic en, input int exp_cnt);
    int q0, tp, cnt, bad;
    rpt_en = en;
    q0 = ptimes.size();
    btn_in = 1'b1;
    wait_level_high();
    hold(80);
    btn_in = 1'b0;
    hold(30);
    cnt = 0;
    bad = 0;
    tp = (ptimes.size() > q0) ? ptimes[q0] : 0;
    for (int i = q0; i < ptimes.size(); i++) begin
      if (ptimes[i] <= tp + 80) begin
        cnt++;
        if (i == q0 + 1 && ptimes[i] - ptimes[i-1] != HOLD_TICKS * TICK_DIV) bad++;
        if (i > q0 + 1 && ptimes[i] - ptimes[i-1] != RPT_TICKS * TICK_DIV) bad++;
      end
    end
    chk(en ? "rpt_on_count" : "rpt_off_count", cnt, exp_cnt);
    chk(en ? "rpt_on_gaps" : "rpt_off_gaps", bad, 0);
  endtask

  initial begin
    int t0, lat, p0, r0, f0, u0;

    rst = 1'b1;
    hold(3);
    chk("rst_level", level, 1'b0);
    chk("rst_pulse", pulse, 1'b0);
    chk("rst_rel", rel_pulse, 1'b0);
    rst = 1'b0;
    hold(10);

    // clean press
    p0 = n_pulse; r0 = n_rel;
    btn_in = 1'b1;
    t0 = cyc;
    wait_level_high();
    lat = cyc - t0 - 1;
    chk("press_coincide", pulse, 1'b1);
    chk("press_lat_window", (lat >= 10 && lat <= 14), 1'b1);
    hold(40 - (cyc - t0));
    chk("press_one_pulse", n_pulse - p0, 1);
    chk("press_no_rel", n_rel - r0, 0);

    // release with one 2-cycle bounce
    p0 = n_pulse; r0 = n_rel; f0 = n_fall;
    btn_in = 1'b0; hold(3);
    btn_in = 1'b1; hold(2);
    btn_in = 1'b0; hold(30);
    chk("rel_one_fall", n_fall - f0, 1);
    chk("rel_one_strobe", n_rel - r0, 1);
    chk("rel_no_pulse", n_pulse - p0, 0);
    chk("rel_level_low", level, 1'b0);

    // bounce reject
    p0 = n_pulse; r0 = n_rel; u0 = n_rise;
    for (int i = 0; i < 10; i++) begin
      btn_in = ~btn_in;
      hold(3);
    end
    btn_in = 1'b0;
    hold(20);
    chk("bounce_no_rise", n_rise - u0, 0);
    chk("bounce_no_pulse", n_pulse - p0, 0);
    chk("bounce_no_rel", n_rel - r0, 0);

    // auto-repeat: 1 press pulse + repeats at 20, 28, ... <= 80 cycles
    repeat_run(1'b1, 1 + ((80 - HOLD_TICKS * TICK_DIV) / (RPT_TICKS * TICK_DIV) + 1));
    repeat_run(1'b0, 1);

    // reset mid-hold with repeat active
    rpt_en = 1'b1;
    btn_in = 1'b1;
    wait_level_high();
    hold(30);
    rst = 1'b1;
    step();
    t0 = cyc;
    rst = 1'b0;
    chk("midrst_level", level, 1'b0);
    chk("midrst_pulse", pulse, 1'b0);
    chk("midrst_rel", rel_pulse, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (pulse === 1'b1) break;
    end
    lat = cyc - t0;
    chk("midrst_repress_window", (pulse === 1'b1 && lat >= 8 && lat <= 14), 1'b1);
    btn_in = 1'b0;
    rpt_en = 1'b0;
    hold(30);

    // counter integration: 9 presses into a 3-bit counter
    rst = 1'b1;
    step();
    rst = 1'b0;
    p0 = n_pulse;
    for (int i = 0; i < 9; i++) begin
      btn_in = 1'b1; hold(20);
      btn_in = 1'b0; hold(20);
    end
    chk("cnt_presses", n_pulse - p0, 9);
    chk("cnt3_wrap", cnt3, 32'(9 % 8));

    // randomized stimulus against the model
    for (int i = 0; i < 150; i++) begin
      btn_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) rpt_en = ~rpt_en;
      rst = ($urandom_range(0, 39) == 0);
      hold(1);
      rst = 1'b0;
      hold($urandom_range(0, 30));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
